// File: rtl/tdm_demux16_pkg.sv
// Types and defaults shared by the TDM demultiplexer and the transmit-side serialiser.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  localparam int N_CH_DEFAULT       = 16;
  localparam int MISS_LIMIT_DEFAULT = 2;

endpackage

// File: rtl/tdm_demux16_if.sv
// Serial-in / parallel-out bus of the TDM demultiplexer.
interface tdm_demux16_if #(
  parameter int N_CH = tdm_pkg::N_CH_DEFAULT
);

  localparam int SW = $clog2(N_CH);

  logic            din;
  logic            din_valid;
  logic            frame_sync;
  logic [N_CH-1:0] dout;
  logic            dout_valid;
  logic [SW-1:0]   slot;
  logic            locked;
  logic            sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, slot, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux16.sv
// Steers each TDM slot back to its channel and presents complete frames in parallel,
// while tracking frame alignment (hunt, lock, realign, drop after missed syncs).
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int N_CH       = N_CH_DEFAULT,
  parameter int MISS_LIMIT = MISS_LIMIT_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux16_if.slave bus
);

  localparam int SW = $clog2(N_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
  localparam logic [2:0]    MISS_MAX  = 3'(MISS_LIMIT);

  tdm_state_t      state;
  logic [N_CH-1:0] stage;
  logic [SW-1:0]   slot_q;
  logic [2:0]      miss_cnt;
  logic [2:0]      miss_next;
  logic [N_CH-1:0] dout_q;
  logic            dout_valid_q;
  logic            locked_q;
  logic            sync_err_q;

  assign miss_next = miss_cnt + 3'd1;

  // A sync at any nonzero slot, including the last one, restarts the frame rather than completing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HUNT;
      stage        <= '0;
      slot_q       <= '0;
      miss_cnt     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            if (bus.frame_sync) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              stage    <= {{(N_CH-1){1'b0}}, bus.din};
              slot_q   <= SW'(1);
              miss_cnt <= '0;
            end
          end
          LOCKED: begin
            if (bus.frame_sync) begin
              if (slot_q != '0) begin
                sync_err_q <= 1'b1;
                stage      <= {{(N_CH-1){1'b0}}, bus.din};
              end else begin
                stage[0] <= bus.din;
              end
              slot_q   <= SW'(1);
              miss_cnt <= '0;
            end else if (slot_q == '0) begin
              // Flywheel through a missing sync until the limit, then give up lock.
              if (miss_next >= MISS_MAX) begin
                state    <= HUNT;
                locked_q <= 1'b0;
                stage    <= '0;
                slot_q   <= '0;
                miss_cnt <= '0;
              end else begin
                stage[0] <= bus.din;
                slot_q   <= SW'(1);
                miss_cnt <= miss_next;
              end
            end else begin
              stage[slot_q] <= bus.din;
              slot_q        <= slot_q + SW'(1);
              if (slot_q == LAST_SLOT) begin
                dout_q       <= {bus.din, stage[N_CH-2:0]};
                dout_valid_q <= 1'b1;
              end
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed and loopback bench for tdm_demux16; a monitor scores every dout_valid word
// against words queued as frames are sent.
module tb_tdm_demux16;

  logic clk;
  logic rst_n;

  tdm_demux16_if #(.N_CH(16)) bus ();

  tdm_demux16 #(.N_CH(16), .MISS_LIMIT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_valid  = 0;
  int          n_serr   = 0;
  logic [15:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard side: every frame the DUT presents must match the oldest queued word.
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_dout_valid: got 0x%0h, expected no frame", bus.dout);
      end else begin
        check("dout_word", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
    end
    if (bus.sync_err === 1'b1) n_serr++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic beat(input logic d, input logic s);
    bus.din        = d;
    bus.frame_sync = s;
    bus.din_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends bits first..last of word; sync is placed on the first bit when requested.
  task automatic apply_stimulus(input logic [15:0] word, input int first, input int last,
                                input bit sync_first, input bit gapped, input bit expect_frame);
    if (expect_frame) exp_q.push_back(word);
    for (int k = first; k <= last; k++) begin
      beat(word[k], sync_first && (k == first));
      if (gapped) begin
        idle(1);
        check("gap_slot_hold", 32'(bus.slot), 32'((k + 1) % 16));
      end
    end
  endtask

  task automatic check_output(input string name, input int valid_before, input int valid_delta,
                              input int serr_before, input int serr_delta);
    check({name, "_valid_count"}, 32'(n_valid - valid_before), 32'(valid_delta));
    check({name, "_syncerr_count"}, 32'(n_serr - serr_before), 32'(serr_delta));
  endtask

  int          v0;
  int          s0;
  logic [15:0] word;
  logic [3:0]  lb_cnt;

  initial begin
    rst_n          = 1'b0;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    check("rst_slot", 32'(bus.slot), 32'h0);
    check("rst_locked", 32'(bus.locked), 32'h0);
    check("rst_sync_err", 32'(bus.sync_err), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Basic frame with lock on the first beat.
    v0 = n_valid; s0 = n_serr;
    apply_stimulus(16'hA5C3, 0, 0, 1'b1, 1'b0, 1'b1);
    check("lock_after_first_beat", 32'(bus.locked), 32'h1);
    check("slot_after_first_beat", 32'(bus.slot), 32'h1);
    apply_stimulus(16'hA5C3, 1, 15, 1'b0, 1'b0, 1'b0);
    check("dout_valid_latency", 32'(bus.dout_valid), 32'h1);
    check("dout_value", 32'(bus.dout), 32'hA5C3);
    idle(2);
    check("dout_valid_single", 32'(bus.dout_valid), 32'h0);
    check("dout_holds", 32'(bus.dout), 32'hA5C3);
    check_output("frame1", v0, 1, s0, 0);

    // Same frame with an idle cycle after every beat.
    v0 = n_valid; s0 = n_serr;
    apply_stimulus(16'hA5C3, 0, 15, 1'b1, 1'b1, 1'b1);
    idle(2);
    check("gapped_dout", 32'(bus.dout), 32'hA5C3);
    check_output("gapped", v0, 1, s0, 0);

    // Sync at slot 7 aborts the partial frame.
    v0 = n_valid; s0 = n_serr;
    apply_stimulus(16'h1234, 0, 6, 1'b1, 1'b0, 1'b0);
    check("slot_before_realign", 32'(bus.slot), 32'h7);
    apply_stimulus(16'hFFFF, 0, 0, 1'b1, 1'b0, 1'b1);
    check("sync_err_pulse", 32'(bus.sync_err), 32'h1);
    check("slot_after_realign", 32'(bus.slot), 32'h1);
    apply_stimulus(16'hFFFF, 1, 15, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("realign_dout", 32'(bus.dout), 32'hFFFF);
    check_output("realign7", v0, 1, s0, 1);

    // Sync on the last slot realigns instead of completing.
    v0 = n_valid; s0 = n_serr;
    apply_stimulus(16'h7777, 0, 14, 1'b1, 1'b0, 1'b0);
    apply_stimulus(16'h8001, 0, 15, 1'b1, 1'b0, 1'b1);
    idle(2);
    check("realign_last_dout", 32'(bus.dout), 32'h8001);
    check_output("realign15", v0, 1, s0, 1);

    // Lost sync: one flywheel frame completes, the next start drops to HUNT.
    v0 = n_valid; s0 = n_serr;
    apply_stimulus(16'h5A5A, 0, 15, 1'b1, 1'b0, 1'b1);
    apply_stimulus(16'h0F0F, 0, 15, 1'b0, 1'b0, 1'b1);
    check("flywheel_still_locked", 32'(bus.locked), 32'h1);
    apply_stimulus(16'h3333, 0, 0, 1'b0, 1'b0, 1'b0);
    check("miss_hunt_locked", 32'(bus.locked), 32'h0);
    check("miss_hunt_slot", 32'(bus.slot), 32'h0);
    apply_stimulus(16'h3333, 1, 15, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("hunt_ignores_slot", 32'(bus.slot), 32'h0);
    check("hunt_dout_held", 32'(bus.dout), 32'h0F0F);
    check_output("lostsync", v0, 2, s0, 0);

    // Reset in the middle of a frame.
    v0 = n_valid; s0 = n_serr;
    apply_stimulus(16'hBEEF, 0, 8, 1'b1, 1'b0, 1'b0);
    check("slot_before_reset", 32'(bus.slot), 32'h9);
    rst_n = 1'b0;
    beat(1'b1, 1'b0);
    check("midrst_dout", 32'(bus.dout), 32'h0);
    check("midrst_slot", 32'(bus.slot), 32'h0);
    check("midrst_locked", 32'(bus.locked), 32'h0);
    rst_n = 1'b1;
    apply_stimulus(16'hFFFF, 0, 15, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("post_rst_slot", 32'(bus.slot), 32'h0);
    check("post_rst_locked", 32'(bus.locked), 32'h0);
    check_output("midrst", v0, 0, s0, 0);

    // Loopback from a counter-driven 16:1 serialiser, back to back.
    v0 = n_valid; s0 = n_serr;
    lb_cnt = 4'd0;
    for (int f = 0; f < 100; f++) begin
      word = 16'($urandom);
      exp_q.push_back(word);
      for (int k = 0; k < 16; k++) begin
        beat(word[lb_cnt], lb_cnt == 4'd0);
        lb_cnt = lb_cnt + 4'd1;
      end
    end
    idle(3);
    check_output("loopback", v0, 100, s0, 0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive-side counterpart of the team's 16:1 channel mux used as a TDM serialiser.
- Takes one serial bit stream plus a frame-sync marker and steers slot k back to channel k.
- Presents each completed 16-channel frame as a parallel word with a one-cycle valid strobe.
- Tracks frame alignment: hunts for sync, locks, flags misaligned sync and drops lock after repeated missing syncs.

Parameters:
- N_CH, 16, channels per frame; power of 2, >= 2; slot counter width SW = log2(N_CH).
- MISS_LIMIT, 2, consecutive frames without sync at slot 0 before falling back to HUNT; range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  1  serial TDM data bit.
- din_valid  in  1  din and frame_sync are sampled only when 1.
- frame_sync  in  1  marks the bit on din as slot 0; qualified by din_valid.
- dout  out  N_CH  last complete frame; bit k = slot k.
- dout_valid  out  1  one-cycle pulse when dout is updated.
- slot  out  SW  slot index the next valid bit will occupy.
- locked  out  1  1 in LOCKED state.
- sync_err  out  1  one-cycle pulse on sync at a nonzero slot while LOCKED.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=HUNT; dout=0, dout_valid=0, slot=0, locked=0, sync_err=0.
  - Internal staging register and miss counter cleared.
  - Reset wins over all other inputs, including mid-frame; the partial frame is discarded.
- Beat: a clk edge with din_valid=1. Non-beat cycles hold all state; dout_valid and sync_err deassert.
- HUNT:
  - Beats without frame_sync are ignored.
  - A beat with frame_sync=1 writes din to stage[0], sets slot=1 and moves to LOCKED.
- LOCKED, beat with frame_sync=0:
  - stage[slot] <= din; slot increments and wraps N_CH-1 -> 0.
- LOCKED, beat with frame_sync=1 at slot==0:
  - Normal frame start; stage[0] <= din; slot=1; miss counter cleared.
- LOCKED, beat with frame_sync=1 at slot!=0:
  - Realign: sync_err pulses the next cycle and the partial frame is discarded (no dout_valid).
  - stage cleared, then stage[0] <= din; slot=1; miss counter cleared; stays LOCKED.
- Frame completion (LOCKED, beat at slot==N_CH-1, frame_sync=0):
  - dout <= stage with bit N_CH-1 replaced by din.
  - dout_valid=1 on the following cycle, i.e. 1-cycle latency from the last bit.
  - dout holds until the next completion or reset.
- Missing sync (LOCKED, beat at slot==0 with frame_sync=0):
  - Bit is still captured as slot 0 (flywheel); miss counter increments.
  - When miss counter reaches MISS_LIMIT: go to HUNT, locked=0, slot=0, stage discarded. That beat is not captured.
- locked equals (state==LOCKED) and is registered.
- A completion and an entry to LOCKED cannot coincide. A sync at slot==N_CH-1 takes the realign path, not completion.
- Back-to-back beats at full rate: one frame per N_CH cycles, with dout_valid pulsing every N_CH cycles.

Decomposition:
- Shared package tdm_pkg:
  - state encoding typedef (HUNT=0, LOCKED=1).
  - N_CH_DEFAULT=16 and MISS_LIMIT_DEFAULT=2, also used by the transmit-side serialiser.
- No sub-module. Slot counter, staging register and FSM form one block. A separate counter module adds ports without reuse.

Test Plan:
- Reset then frame: sync on slot 0, 16 beats of bits from 0xA5C3 (bit k at slot k) -> dout=16'hA5C3, dout_valid pulses once 1 cycle after the 16th beat, locked=1 from the cycle after the first beat.
- Gapped input: same frame with din_valid=0 inserted between every beat -> identical dout=16'hA5C3, single pulse, slot holds during gaps.
- Misaligned sync: frame 0x1234 aborted by sync at slot 7, followed by full frame 0xFFFF -> sync_err pulse once, no dout_valid for the partial frame, then dout=16'hFFFF.
- Lost sync: lock, then 3 frames with no frame_sync (MISS_LIMIT=2) -> frame 2 (no sync, flywheel) still completes with dout_valid; at the start of frame 3 the FSM enters HUNT, locked=0, slot=0, and no further dout_valid.
- Reset mid-frame: rst_n=0 at slot 9 -> next cycle dout=0, slot=0, locked=0; beats without sync are ignored afterward.
- Loopback: the team's 16:1 mux driven by a 4-bit counter with sync at count 0, random 16-bit words, 100 frames -> every dout equals the transmitted word, with zero sync_err.
